// File: rtl/spu_regfile_mp.sv
// SPU register file: 2 write ports (even/odd), 3 read ports, post-reset clear sweep.
// Odd-pipe writes win on address collisions; reads see same-cycle writes.
module spu_regfile_mp #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 128,
    parameter int ABITS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_e,
    input  logic [ABITS-1:0] wa_e,
    input  logic [WIDTH-1:0] wd_e,
    input  logic             we_o,
    input  logic [ABITS-1:0] wa_o,
    input  logic [WIDTH-1:0] wd_o,
    input  logic [2:0]       re,
    input  logic [ABITS-1:0] ra,
    input  logic [ABITS-1:0] rb,
    input  logic [ABITS-1:0] rc,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic [WIDTH-1:0] rd_c,
    output logic [2:0]       rd_vld,
    output logic             busy,
    output logic             wr_conflict
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ABITS:0] LIM = (ABITS + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t           state;
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_e;
    logic             wr_o;

    function automatic logic in_range(input logic [ABITS-1:0] a);
        return {1'b0, a} < LIM;
    endfunction

    assign wr_e = we_e && in_range(wa_e);
    assign wr_o = we_o && in_range(wa_o);

    // Bypass order: odd write, then even write, then stored entry.
    function automatic logic [WIDTH-1:0] rdata(input logic [ABITS-1:0] a);
        if (wr_o && wa_o == a) return wd_o;
        if (wr_e && wa_e == a) return wd_e;
        if (in_range(a)) return mem[a[IW-1:0]];
        return '0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wr_e) mem[wa_e[IW-1:0]] <= wd_e;
                if (wr_o) mem[wa_o[IW-1:0]] <= wd_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CLEAR;
            cnt         <= '0;
            busy        <= 1'b1;
            rd_a        <= '0;
            rd_b        <= '0;
            rd_c        <= '0;
            rd_vld      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    rd_vld      <= '0;
                    wr_conflict <= 1'b0;
                    if (cnt == LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                READY: begin
                    wr_conflict <= we_e && we_o && (wa_e == wa_o);
                    rd_vld      <= re;
                    if (re[0]) rd_a <= rdata(ra);
                    if (re[1]) rd_b <= rdata(rb);
                    if (re[2]) rd_c <= rdata(rc);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_regfile_mp.sv
// Bench for spu_regfile_mp: directed cases plus random traffic
// checked each cycle against an array model of the register file.
module tb_spu_regfile_mp;

    localparam int W  = 128;
    localparam int D  = 128;
    localparam int AB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we_e, we_o;
    logic [AB-1:0] wa_e, wa_o, ra, rb, rc;
    logic [W-1:0]  wd_e, wd_o;
    logic [2:0]    re;
    logic [W-1:0]  rd_a, rd_b, rd_c;
    logic [2:0]    rd_vld;
    logic          busy, wr_conflict;

    int n_checks = 0;
    int n_pass   = 0;

    spu_regfile_mp #(.WIDTH(W), .DEPTH(D), .ABITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .we_e(we_e), .wa_e(wa_e), .wd_e(wd_e),
        .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o),
        .re(re), .ra(ra), .rb(rb), .rc(rc),
        .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .rd_vld(rd_vld), .busy(busy), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Model: the array after this edge's writes is what reads return.
    logic [W-1:0] mdl [D];
    logic [W-1:0] e_rd [3];
    logic [2:0]   e_vld = '0;
    logic         e_cf = 1'b0;
    int           sweep = 0;

    always @(posedge clk) begin
        logic [AB-1:0] adr;
        if (!rst_n) begin
            sweep = D;
            for (int i = 0; i < 3; i++) e_rd[i] = '0;
            e_vld = '0;
            e_cf  = 1'b0;
        end else if (sweep > 0) begin
            mdl[D - sweep] = '0;
            sweep--;
            e_vld = '0;
            e_cf  = 1'b0;
        end else begin
            if (we_e && wa_e < D) mdl[wa_e] = wd_e;
            if (we_o && wa_o < D) mdl[wa_o] = wd_o;
            e_cf = we_e && we_o && (wa_e == wa_o);
            for (int i = 0; i < 3; i++) begin
                adr = (i == 0) ? ra : (i == 1) ? rb : rc;
                if (re[i]) e_rd[i] = (adr < D) ? mdl[adr] : '0;
            end
            e_vld = re;
        end
        #1;
        check("rd_a", rd_a, e_rd[0]);
        check("rd_b", rd_b, e_rd[1]);
        check("rd_c", rd_c, e_rd[2]);
        check("rd_vld", W'(rd_vld), W'(e_vld));
        check("busy", W'(busy), W'(sweep != 0));
        check("wr_conflict", W'(wr_conflict), W'(e_cf));
    end

    task automatic idle();
        we_e = 0; we_o = 0; re = 3'b000;
        wa_e = '0; wa_o = '0; wd_e = '0; wd_o = '0;
        ra = '0; rb = '0; rc = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts busy samples starting at the sample after the last reset edge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            step();
        end
    endtask

    logic [W-1:0] pat_a5;
    int           nb;

    initial begin
        pat_a5 = {16{8'hA5}};
        idle();
        rst_n = 0;
        step(); step();
        check("reset_busy", W'(busy), W'(1));
        check("reset_vld", W'(rd_vld), '0);
        check("reset_rd_a", rd_a, '0);
        check("reset_cf", W'(wr_conflict), '0);

        rst_n = 1;
        count_busy(nb);
        check("busy_cycles", W'(nb), W'(128));

        re = 3'b111; ra = 0; rb = 64; rc = 127;
        step();
        check("clr_rd_a", rd_a, '0);
        check("clr_rd_b", rd_b, '0);
        check("clr_rd_c", rd_c, '0);
        check("clr_vld", W'(rd_vld), W'(3'b111));

        idle(); we_e = 1; wa_e = 5; wd_e = pat_a5;
        step();
        idle(); re = 3'b111; ra = 5; rb = 5; rc = 5;
        step();
        check("a5_rd_a", rd_a, pat_a5);
        check("a5_rd_b", rd_b, pat_a5);
        check("a5_rd_c", rd_c, pat_a5);
        check("a5_vld", W'(rd_vld), W'(3'b111));

        idle();
        we_e = 1; wa_e = 9; wd_e = 1;
        we_o = 1; wa_o = 9; wd_o = 2;
        re = 3'b001; ra = 9;
        step();
        check("dual_rd_a", rd_a, W'(2));
        check("dual_cf_on", W'(wr_conflict), W'(1));
        idle();
        step();
        check("dual_cf_off", W'(wr_conflict), '0);
        re = 3'b001; ra = 9;
        step();
        check("dual_later", rd_a, W'(2));

        idle(); we_e = 1; wa_e = 130; wd_e = '1;
        step();
        idle(); re = 3'b011; ra = 130; rb = 2;
        step();
        check("oor_rd", rd_a, '0);
        check("oor_alias", rd_b, '0);

        idle(); re = 3'b001; ra = 5;
        step();
        check("hold_vld1", W'(rd_vld), W'(3'b001));
        check("hold_a1", rd_a, pat_a5);
        idle();
        step();
        check("hold_vld0", W'(rd_vld), '0);
        check("hold_a0", rd_a, pat_a5);

        for (int k = 0; k < 1500; k++) begin
            we_e = ($urandom_range(0, 1) == 1);
            we_o = ($urandom_range(0, 2) == 0);
            wa_e = AB'($urandom_range(0, 139));
            wa_o = ($urandom_range(0, 3) == 0) ? wa_e : AB'($urandom_range(0, 139));
            wd_e = {$urandom, $urandom, $urandom, $urandom};
            wd_o = {$urandom, $urandom, $urandom, $urandom};
            re   = 3'($urandom);
            ra   = ($urandom_range(0, 3) == 0) ? wa_o : AB'($urandom_range(0, 135));
            rb   = ($urandom_range(0, 3) == 0) ? wa_e : AB'($urandom_range(0, 135));
            rc   = AB'($urandom_range(0, 135));
            step();
        end

        idle(); we_o = 1; wa_o = 3; wd_o = 77;
        step();
        idle(); rst_n = 0;
        step();
        rst_n = 1;
        we_e = 1; wa_e = 3; wd_e = 55;
        we_o = 1; wa_o = 100; wd_o = 66;
        re = 3'b111;
        for (int k = 0; k < 50; k++) step();
        rst_n = 0;
        step();
        rst_n = 1;
        count_busy(nb);
        check("resweep_cycles", W'(nb), W'(128));
        idle(); re = 3'b011; ra = 3; rb = 100;
        step();
        check("sweep_lost_3", rd_a, '0);
        check("sweep_lost_100", rd_b, '0);

        for (int k = 0; k < 300; k++) begin
            we_e = ($urandom_range(0, 1) == 1);
            we_o = ($urandom_range(0, 1) == 1);
            wa_e = AB'($urandom_range(0, 15));
            wa_o = AB'($urandom_range(0, 15));
            wd_e = {$urandom, $urandom, $urandom, $urandom};
            wd_o = {$urandom, $urandom, $urandom, $urandom};
            re   = 3'($urandom);
            ra   = AB'($urandom_range(0, 15));
            rb   = AB'($urandom_range(0, 15));
            rc   = AB'($urandom_range(0, 15));
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
